// File: rtl/frequency_encoder.sv
// frequency_encoder
//
// Measures the frequency of an asynchronous square wave by counting its
// rising edges over a gate window of GATE_CYCLES clocks. Each completed
// window is reported as an 8-bit count that saturates at 8'hFF, together
// with a one-cycle valid strobe. Windows run back-to-back while enable is
// held high. Dropping enable abandons the current window without a report.
//
// Optional build macro: FREQ_ENC_GLITCH_FILTER_EN
//   When it is defined, a 2-cycle stability filter sits between the
//   synchronizer and the edge detector. Single-cycle pulses and gaps are
//   ignored, and the input latency grows by 2 cycles.
//
// Parameters:
//   GATE_CYCLES  gate window length in clk cycles (2..65535)
//   SYNC_STAGES  synchronizer depth on freq_in (2..4)
//
// Ports:
//   clk                  system clock, rising edge
//   rst                  asynchronous reset, active-high
//   enable               measurement enable, synchronous to clk
//   freq_in              asynchronous signal under measurement
//   encoded_binary_code  last completed window's edge count, saturated at 255
//   code_valid           one-cycle pulse when encoded_binary_code updates
//   overflow             last completed window reached 255 or more edges
module frequency_encoder #(
   parameter int GATE_CYCLES = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       freq_in,
   output logic [7:0] encoded_binary_code,
   output logic       code_valid,
   output logic       overflow
);

   localparam int WIN_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [SYNC_STAGES-1:0] sync_p0;
   logic                 level;
   logic                 hist_p0;
   logic                 rise_p1;
   logic [WIN_W-1:0]     win_cnt;
   logic [7:0]           edge_cnt;
   logic [7:0]           edge_next;
   logic                 win_done;

   function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic hit);
      return (hit && (cnt != 8'hFF)) ? cnt + 8'd1 : cnt;
   endfunction

   // ---- stage p0: synchronizer ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= '0;
      end else begin
         sync_p0 <= {sync_p0[SYNC_STAGES-2:0], freq_in};
      end
   end

`ifdef FREQ_ENC_GLITCH_FILTER_EN
   // ---- optional stability filter ----
   // The filtered level only follows the synchronized level once two
   // consecutive samples agree, so 1-cycle pulses and gaps never get through.
   logic raw_d;
   logic filt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raw_d <= 1'b0;
         filt  <= 1'b0;
      end else begin
         raw_d <= sync_p0[SYNC_STAGES-1];
         if (sync_p0[SYNC_STAGES-1] == raw_d) begin
            filt <= raw_d;
         end
      end
   end

   assign level = filt;
`else
   assign level = sync_p0[SYNC_STAGES-1];
`endif

   // ---- stage p1: edge detector ----
   // The history flop tracks the level in every state, so in ARM it is holding
   // the current level and a static input can never look like an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_p0 <= 1'b0;
         rise_p1 <= 1'b0;
      end else begin
         hist_p0 <= level;
         rise_p1 <= level & ~hist_p0;
      end
   end

   // ---- control: state register and next-state logic ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (enable) state_next = ARM;
         ARM:     state_next = enable ? MEASURE : IDLE;
         MEASURE: if (!enable) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Final cycle of a window. An edge pulse in this same cycle still counts.
   assign win_done  = (state == MEASURE) && enable && (win_cnt == WIN_LAST);
   assign edge_next = sat_inc(edge_cnt, rise_p1);

   // ---- window and edge counters ----
   // Both counters are cleared in IDLE and ARM, when a window is abandoned, and
   // at a window boundary so that the next window starts with no dead cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt  <= '0;
         edge_cnt <= 8'h00;
      end else if ((state != MEASURE) || !enable || win_done) begin
         win_cnt  <= '0;
         edge_cnt <= 8'h00;
      end else begin
         win_cnt  <= win_cnt + WIN_W'(1);
         edge_cnt <= edge_next;
      end
   end

   // ---- output register ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         encoded_binary_code <= 8'h00;
         code_valid          <= 1'b0;
         overflow            <= 1'b0;
      end else begin
         code_valid <= win_done;
         if (win_done) begin
            encoded_binary_code <= edge_next;
            overflow            <= (edge_next == 8'hFF);
         end
      end
   end

endmodule
